dsp_cmd_issuer: RTL

- Initiator-side front end for the DSP multiply/accumulate block.
- Accepts operand commands on a valid/ready stream and drives the DSP operand and control pins, one command per cycle.
- Tracks each issued operation through the DSP's programmable output pipeline and captures the result at the correct cycle.
- Returns results in order on a valid/ready stream through a small credit-protected result FIFO.

---
 rtl/dsp_cmd_issuer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/dsp_cmd_issuer.sv
// Front end for the DSP multiply/accumulate block: issues one command per cycle,
// tracks each result through the programmable DSP output pipe and returns results in order.
module dsp_cmd_issuer #(
    parameter int WIDTH         = 16,
    parameter int SHIFT_BITS    = 2,
    parameter int PIPELINE_BITS = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_aa,
    input  logic [WIDTH-1:0]         cmd_bb,
    input  logic [2*WIDTH-1:0]       cmd_cc,
    input  logic [SHIFT_BITS-1:0]    cmd_shift_amount,
    input  logic                     cmd_shift_dir,
    input  logic [1:0]               cmd_mode,
    input  logic                     cmd_mac,
    input  logic [PIPELINE_BITS-1:0] cfg_pipe_stages,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2*WIDTH-1:0]       res_data,
    output logic                     dsp_start,
    output logic [WIDTH-1:0]         dsp_aa,
    output logic [WIDTH-1:0]         dsp_bb,
    output logic [2*WIDTH-1:0]       dsp_cc,
    output logic [SHIFT_BITS-1:0]    dsp_shift_amount,
    output logic                     dsp_shift_dir,
    output logic [1:0]               dsp_mode,
    output logic                     dsp_mac,
    output logic [PIPELINE_BITS-1:0] dsp_pipe_stages,
    input  logic [2*WIDTH-1:0]       dsp_out,
    output logic                     busy,
    output logic                     err_illegal
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TAPS  = PIPELINE_BITS;
    localparam logic [PIPELINE_BITS-1:0] MAX_D   = PIPELINE_BITS'(PIPELINE_BITS);
    localparam logic [CNT_W:0]           DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_APPLY = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [PIPELINE_BITS-1:0] r_depth;
    logic [PIPELINE_BITS-1:0] w_cfg_clamped;
    logic [TAPS-1:0]          r_tap;
    logic [TAPS-1:0]          w_tap_en;
    logic [TAPS-1:0]          w_tap_sel;
    logic [CNT_W-1:0]         r_inflight;
    logic [CNT_W-1:0]         r_count;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [2*WIDTH-1:0]       r_mem [FIFO_DEPTH];
    logic                     r_err;
    logic                     w_accept;
    logic                     w_legal;
    logic                     w_issue;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_credit_ok;
    logic                     w_tracked;
    logic [CNT_W:0]           w_used;

    // Clamp the requested depth to the deepest pipe the DSP supports.
    always_comb begin
        if (cfg_pipe_stages > MAX_D) begin
            w_cfg_clamped = MAX_D;
        end else begin
            w_cfg_clamped = cfg_pipe_stages;
        end
    end

    assign w_accept    = cmd_valid & cmd_ready;
    assign w_legal     = (cmd_mode != 2'b11);
    assign w_issue     = w_accept & w_legal;
    assign w_pop       = (r_count != '0) & res_ready;
    assign w_tracked   = (r_depth != '0);
    assign w_used      = (CNT_W + 1)'(r_count) + (CNT_W + 1)'(r_inflight);
    assign w_credit_ok = (w_used < DEPTH_L);

    // Taps beyond the applied depth are held at zero so a later deeper setting sees no stale bits.
    always_comb begin
        w_tap_en  = '0;
        w_tap_sel = '0;
        for (int i = 0; i < TAPS; i++) begin
            w_tap_en[i]  = (PIPELINE_BITS'(i) < r_depth);
            w_tap_sel[i] = (PIPELINE_BITS'(i + 1) == r_depth);
        end
    end

    assign w_push = w_tracked ? |(r_tap & w_tap_sel) : w_issue;

    // Valid shift register marking the cycle each tracked result leaves the DSP pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tap <= '0;
        end else begin
            r_tap <= {r_tap[TAPS-2:0], w_issue} & w_tap_en;
        end
    end

    // In-flight credit count; a same-cycle issue and push cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue & w_tracked, w_push & w_tracked})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Result FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= dsp_out;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // State, applied depth and sticky illegal-mode flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_APPLY;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_APPLY) begin
                r_depth <= w_cfg_clamped;
            end
            r_err <= r_err | (w_accept & ~w_legal);
        end
    end

    // Next state and command acceptance; a depth change first drains the pipe.
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_cfg_clamped != r_depth) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_RUN;
                    cmd_ready    = w_credit_ok;
                end
            end
            ST_DRAIN: begin
                if (r_inflight == '0) begin
                    w_state_next = ST_APPLY;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_APPLY: w_state_next = ST_RUN;
            default:  w_state_next = ST_APPLY;
        endcase
    end

    // DSP pins follow the accepted command only on a legal issue and are zero otherwise.
    always_comb begin
        if (w_issue) begin
            dsp_start        = 1'b1;
            dsp_aa           = cmd_aa;
            dsp_bb           = cmd_bb;
            dsp_cc           = cmd_cc;
            dsp_shift_amount = cmd_shift_amount;
            dsp_shift_dir    = cmd_shift_dir;
            dsp_mode         = cmd_mode;
            dsp_mac          = cmd_mac;
        end else begin
            dsp_start        = 1'b0;
            dsp_aa           = '0;
            dsp_bb           = '0;
            dsp_cc           = '0;
            dsp_shift_amount = '0;
            dsp_shift_dir    = 1'b0;
            dsp_mode         = 2'b00;
            dsp_mac          = 1'b0;
        end
    end

    assign dsp_pipe_stages = r_depth;
    assign res_valid       = (r_count != '0);
    assign res_data        = r_mem[r_rd_ptr];
    assign busy            = (r_inflight != '0) | (r_state != ST_RUN);
    assign err_illegal     = r_err;

endmodule
